// File: rtl/tinyml_cmd_router.sv
// tinyml_cmd_router
//   Routes CPU custom-instruction commands to one of two command/response
//   slaves and returns their responses to the CPU in command-issue order.
//   function_id[9] selects the slave: 0 = tinyML accelerator, 1 = user unit.
//   Each issued command records its target in a small order FIFO; only the
//   slave named at the FIFO head may hand back a response. Responses pass
//   through one output register towards the CPU. With USER_ENABLE=0, user
//   commands are accepted and answered internally with ERR_RSP.
//
// Ports
//   clk, rstn                         clock, asynchronous active-low reset
//   cpu_cmd_*                         command from the CPU (valid/ready)
//   cpu_rsp_*                         registered response to the CPU
//   slv_cmd_*                         operands broadcast to both slaves
//   accel_cmd_* / accel_rsp_*         accelerator handshakes
//   user_cmd_*  / user_rsp_*          user-unit handshakes
//   outstanding                       commands issued, response not yet taken
//   busy                              outstanding != 0 or response pending
module tinyml_cmd_router #(
  parameter int          ORDER_DEPTH = 4,
  parameter int          ORDER_AW    = 2,
  parameter int          USER_ENABLE = 1,
  parameter logic [31:0] ERR_RSP     = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cpu_cmd_valid,
  output logic                cpu_cmd_ready,
  input  logic [9:0]          cpu_cmd_function_id,
  input  logic [31:0]         cpu_cmd_inputs_0,
  input  logic [31:0]         cpu_cmd_inputs_1,
  output logic                cpu_rsp_valid,
  input  logic                cpu_rsp_ready,
  output logic [31:0]         cpu_rsp_outputs_0,
  output logic [9:0]          slv_cmd_function_id,
  output logic [31:0]         slv_cmd_inputs_0,
  output logic [31:0]         slv_cmd_inputs_1,
  output logic                accel_cmd_valid,
  input  logic                accel_cmd_ready,
  input  logic                accel_rsp_valid,
  output logic                accel_rsp_ready,
  input  logic [31:0]         accel_rsp_outputs_0,
  output logic                user_cmd_valid,
  input  logic                user_cmd_ready,
  input  logic                user_rsp_valid,
  output logic                user_rsp_ready,
  input  logic [31:0]         user_rsp_outputs_0,
  output logic [ORDER_AW:0]   outstanding,
  output logic                busy
);

  localparam logic [ORDER_AW:0] FULL_CNT = (ORDER_AW + 1)'(ORDER_DEPTH);
  localparam logic              USER_EN  = (USER_ENABLE != 0);

  // Order FIFO: one bit per outstanding command, 1 = user unit.
  logic                order_q [ORDER_DEPTH];
  logic [ORDER_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ORDER_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ORDER_AW:0]   count_q, count_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;

  logic        full, empty, tgt, head, can_load;
  logic        push, pop, accel_fire, user_fire, err_fire;
  logic [31:0] load_data;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign tgt   = cpu_cmd_function_id[9];
  assign head  = order_q[rd_ptr_q];

  // Command path is purely combinational; operands go to both slaves and
  // only the selected slave sees valid.
  assign slv_cmd_function_id = cpu_cmd_function_id;
  assign slv_cmd_inputs_0    = cpu_cmd_inputs_0;
  assign slv_cmd_inputs_1    = cpu_cmd_inputs_1;

  assign accel_cmd_valid = cpu_cmd_valid & ~tgt & ~full;
  assign user_cmd_valid  = cpu_cmd_valid & tgt & ~full & USER_EN;
  // A disabled user slot always accepts; the error word is produced later.
  assign cpu_cmd_ready   = ~full & (tgt ? (USER_EN ? user_cmd_ready : 1'b1)
                                        : accel_cmd_ready);
  assign push = cpu_cmd_valid & cpu_cmd_ready;

  // Only the slave at the FIFO head is offered ready, and only when the
  // output register can take a new word this cycle.
  assign can_load        = ~rsp_valid_q | cpu_rsp_ready;
  assign accel_rsp_ready = ~empty & ~head & can_load;
  assign user_rsp_ready  = ~empty & head & can_load & USER_EN;

  assign accel_fire = accel_rsp_valid & accel_rsp_ready;
  assign user_fire  = user_rsp_valid & user_rsp_ready;
  assign err_fire   = ~USER_EN & ~empty & head & can_load;
  assign pop        = accel_fire | user_fire | err_fire;

  assign load_data = accel_fire ? accel_rsp_outputs_0 :
                     user_fire  ? user_rsp_outputs_0  : ERR_RSP;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (push) wr_ptr_d = wr_ptr_q + ORDER_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ORDER_AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (ORDER_AW + 1)'(1);
      2'b01:   count_d = count_q - (ORDER_AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = load_data;
    end else if (cpu_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ORDER_DEPTH; i++) order_q[i] <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (push) order_q[wr_ptr_q] <= tgt;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cpu_rsp_valid     = rsp_valid_q;
  assign cpu_rsp_outputs_0 = rsp_data_q;
  assign outstanding       = count_q;
  assign busy              = ~empty | rsp_valid_q;

endmodule

// File: tb/tb_tinyml_cmd_router.sv
module tb_tinyml_cmd_router;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_cmd_valid, cmd_valid0;
  logic [9:0]  fid;
  logic [31:0] in0, in1;
  logic        cpu_rsp_ready;
  logic        accel_cmd_ready, accel_rsp_valid, user_cmd_ready, user_rsp_valid;
  logic [31:0] accel_rsp_data, user_rsp_data;

  // Main instance (user slot present)
  logic        cpu_cmd_ready, cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic [9:0]  slv_fid;
  logic [31:0] slv_in0, slv_in1;
  logic        accel_cmd_valid, accel_rsp_ready, user_cmd_valid, user_rsp_ready;
  logic [2:0]  outstanding;
  logic        busy;

  // Second instance (user slot disabled)
  logic        e_cmd_ready, e_rsp_valid;
  logic [31:0] e_rsp_data;
  logic [9:0]  e_slv_fid;
  logic [31:0] e_slv_in0, e_slv_in1;
  logic        e_accel_cmd_valid, e_accel_rsp_ready, e_user_cmd_valid, e_user_rsp_ready;
  logic [2:0]  e_outstanding;
  logic        e_busy;

  always #5 clk = ~clk;

  tinyml_cmd_router dut (
    .clk(clk), .rstn(rstn),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_cmd_function_id(fid), .cpu_cmd_inputs_0(in0), .cpu_cmd_inputs_1(in1),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_outputs_0(cpu_rsp_data),
    .slv_cmd_function_id(slv_fid), .slv_cmd_inputs_0(slv_in0), .slv_cmd_inputs_1(slv_in1),
    .accel_cmd_valid(accel_cmd_valid), .accel_cmd_ready(accel_cmd_ready),
    .accel_rsp_valid(accel_rsp_valid), .accel_rsp_ready(accel_rsp_ready),
    .accel_rsp_outputs_0(accel_rsp_data),
    .user_cmd_valid(user_cmd_valid), .user_cmd_ready(user_cmd_ready),
    .user_rsp_valid(user_rsp_valid), .user_rsp_ready(user_rsp_ready),
    .user_rsp_outputs_0(user_rsp_data),
    .outstanding(outstanding), .busy(busy)
  );

  tinyml_cmd_router #(.USER_ENABLE(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .cpu_cmd_valid(cmd_valid0), .cpu_cmd_ready(e_cmd_ready),
    .cpu_cmd_function_id(fid), .cpu_cmd_inputs_0(in0), .cpu_cmd_inputs_1(in1),
    .cpu_rsp_valid(e_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_outputs_0(e_rsp_data),
    .slv_cmd_function_id(e_slv_fid), .slv_cmd_inputs_0(e_slv_in0), .slv_cmd_inputs_1(e_slv_in1),
    .accel_cmd_valid(e_accel_cmd_valid), .accel_cmd_ready(accel_cmd_ready),
    .accel_rsp_valid(accel_rsp_valid), .accel_rsp_ready(e_accel_rsp_ready),
    .accel_rsp_outputs_0(accel_rsp_data),
    .user_cmd_valid(e_user_cmd_valid), .user_cmd_ready(user_cmd_ready),
    .user_rsp_valid(user_rsp_valid), .user_rsp_ready(e_user_rsp_ready),
    .user_rsp_outputs_0(user_rsp_data),
    .outstanding(e_outstanding), .busy(e_busy)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: targets of commands whose slave response is not yet
  // taken, words each slave still owes, and the words the CPU must see in
  // command order.
  bit          order_m [$];
  logic [31:0] pend_a [$];
  logic [31:0] pend_u [$];
  logic [31:0] exp_all [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One randomized cycle; drain mode stops new commands and keeps all readies high.
  task automatic rand_cycle(input bit drain);
    logic [31:0] w;
    logic        exp_rdy;
    cpu_cmd_valid   = drain ? 1'b0 : 1'($urandom_range(0, 1));
    fid             = 10'($urandom);
    in0             = $urandom;
    in1             = $urandom;
    accel_cmd_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    user_cmd_ready  = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    accel_rsp_valid = (pend_a.size() != 0) && (drain || $urandom_range(0, 1) != 0);
    accel_rsp_data  = (pend_a.size() != 0) ? pend_a[0] : $urandom;
    user_rsp_valid  = (pend_u.size() != 0) && (drain || $urandom_range(0, 1) != 0);
    user_rsp_data   = (pend_u.size() != 0) ? pend_u[0] : $urandom;
    cpu_rsp_ready   = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    chk("r_outstanding", 32'(outstanding), 32'(order_m.size()));
    exp_rdy = (order_m.size() < 4) && (fid[9] ? user_cmd_ready : accel_cmd_ready);
    chk("r_cmd_ready", 32'(cpu_cmd_ready), 32'(exp_rdy));
    if (accel_rsp_valid && accel_rsp_ready) begin
      chk("r_accel_turn", 32'(order_m[0]), 32'd0);
      void'(pend_a.pop_front());
      void'(order_m.pop_front());
    end
    if (user_rsp_valid && user_rsp_ready) begin
      chk("r_user_turn", 32'(order_m[0]), 32'd1);
      void'(pend_u.pop_front());
      void'(order_m.pop_front());
    end
    if (cpu_rsp_valid && cpu_rsp_ready) begin
      if (exp_all.size() == 0) chk("r_spurious_rsp", 32'd1, 32'd0);
      else chk("r_rsp_data", cpu_rsp_data, exp_all.pop_front());
    end
    if (cpu_cmd_valid && cpu_cmd_ready) begin
      if (fid[9]) begin
        chk("r_user_cmd_hs", 32'(user_cmd_valid & user_cmd_ready & ~accel_cmd_valid), 32'd1);
        w = in0 ^ in1;
        pend_u.push_back(w);
      end else begin
        chk("r_accel_cmd_hs", 32'(accel_cmd_valid & accel_cmd_ready & ~user_cmd_valid), 32'd1);
        w = in0 + in1;
        pend_a.push_back(w);
      end
      order_m.push_back(fid[9]);
      exp_all.push_back(w);
    end
    step();
  endtask

  initial begin
    rstn = 1'b0; cpu_cmd_valid = 0; cmd_valid0 = 0; fid = '0; in0 = '0; in1 = '0;
    cpu_rsp_ready = 0; accel_cmd_ready = 0; accel_rsp_valid = 0; user_cmd_ready = 0;
    user_rsp_valid = 0; accel_rsp_data = '0; user_rsp_data = '0;
    step(); step();
    rstn = 1'b1;
    step();
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_rsp_valid", 32'(cpu_rsp_valid), 0);
    chk("rst_rsp_data", cpu_rsp_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_accel_rsp_ready", 32'(accel_rsp_ready), 0);

    // 1: single accelerator command
    cpu_cmd_valid = 1; fid = 10'h005; in0 = 1; in1 = 2; accel_cmd_ready = 1; cpu_rsp_ready = 1;
    #1;
    chk("t1_accel_cmd_valid", 32'(accel_cmd_valid), 1);
    chk("t1_user_cmd_valid", 32'(user_cmd_valid), 0);
    chk("t1_slv_fid", 32'(slv_fid), 32'h005);
    step();
    cpu_cmd_valid = 0;
    #1;
    chk("t1_accel_pulse_end", 32'(accel_cmd_valid), 0);
    chk("t1_outstanding", 32'(outstanding), 1);
    step();
    accel_rsp_valid = 1; accel_rsp_data = 32'h3;
    #1;
    chk("t1_accel_rsp_ready", 32'(accel_rsp_ready), 1);
    step();
    accel_rsp_valid = 0;
    chk("t1_rsp_valid", 32'(cpu_rsp_valid), 1);
    chk("t1_rsp_data", cpu_rsp_data, 32'h3);
    chk("t1_outstanding0", 32'(outstanding), 0);
    step();
    chk("t1_rsp_valid_drop", 32'(cpu_rsp_valid), 0);
    chk("t1_busy", 32'(busy), 0);

    // 2: user answers first but must wait for the older accel command
    cpu_cmd_valid = 1; fid = 10'h001;
    step();
    fid = 10'h201; user_cmd_ready = 1;
    #1;
    chk("t2_user_cmd_valid", 32'(user_cmd_valid), 1);
    step();
    cpu_cmd_valid = 0;
    user_rsp_valid = 1; user_rsp_data = 32'hBBBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_user_stalled", 32'(user_rsp_ready), 0);
      step();
    end
    accel_rsp_valid = 1; accel_rsp_data = 32'hAAAA;
    #1;
    chk("t2_accel_ready", 32'(accel_rsp_ready), 1);
    chk("t2_user_still_stalled", 32'(user_rsp_ready), 0);
    step();
    accel_rsp_valid = 0;
    #1;
    chk("t2_first_valid", 32'(cpu_rsp_valid), 1);
    chk("t2_first_data", cpu_rsp_data, 32'hAAAA);
    chk("t2_user_ready", 32'(user_rsp_ready), 1);
    step();
    user_rsp_valid = 0;
    chk("t2_second_valid", 32'(cpu_rsp_valid), 1);
    chk("t2_second_data", cpu_rsp_data, 32'hBBBB);
    step();
    chk("t2_idle", 32'(cpu_rsp_valid), 0);
    chk("t2_outstanding", 32'(outstanding), 0);

    // 3: full FIFO blocks the fifth command until the cycle after a pop
    cpu_cmd_valid = 1; fid = 10'h002;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("t3_outstanding4", 32'(outstanding), 4);
    chk("t3_cmd_ready_full", 32'(cpu_cmd_ready), 0);
    chk("t3_accel_cmd_valid_full", 32'(accel_cmd_valid), 0);
    accel_rsp_valid = 1; accel_rsp_data = 32'h10;
    #1;
    chk("t3_pop_ready", 32'(accel_rsp_ready), 1);
    chk("t3_no_bypass", 32'(cpu_cmd_ready), 0);
    step();
    accel_rsp_valid = 0;
    #1;
    chk("t3_ready_after_pop", 32'(cpu_cmd_ready), 1);
    chk("t3_outstanding3", 32'(outstanding), 3);
    step();
    cpu_cmd_valid = 0;
    chk("t3_outstanding_refill", 32'(outstanding), 4);
    accel_rsp_valid = 1;
    for (int i = 0; i < 20 && outstanding != 0; i++) step();
    accel_rsp_valid = 0;
    step();
    chk("t3_drained", 32'(outstanding), 0);
    chk("t3_busy", 32'(busy), 0);

    // 4: CPU backpressure
    cpu_rsp_ready = 0; cpu_cmd_valid = 1; fid = 10'h003;
    step(); step();
    cpu_cmd_valid = 0;
    accel_rsp_valid = 1; accel_rsp_data = 32'h111;
    #1;
    chk("t4_first_ready", 32'(accel_rsp_ready), 1);
    step();
    accel_rsp_data = 32'h222;
    #1;
    chk("t4_held_valid", 32'(cpu_rsp_valid), 1);
    chk("t4_held_data", cpu_rsp_data, 32'h111);
    chk("t4_blocked", 32'(accel_rsp_ready), 0);
    step();
    chk("t4_still_held", cpu_rsp_data, 32'h111);
    chk("t4_still_blocked", 32'(accel_rsp_ready), 0);
    chk("t4_outstanding1", 32'(outstanding), 1);
    cpu_rsp_ready = 1;
    #1;
    chk("t4_unblocked", 32'(accel_rsp_ready), 1);
    step();
    accel_rsp_valid = 0;
    chk("t4_second_valid", 32'(cpu_rsp_valid), 1);
    chk("t4_second_data", cpu_rsp_data, 32'h222);
    step();
    chk("t4_idle_valid", 32'(cpu_rsp_valid), 0);
    chk("t4_idle_busy", 32'(busy), 0);

    // 5: disabled user slot answers internally
    cmd_valid0 = 1; fid = 10'h3FF; user_cmd_ready = 0;
    #1;
    chk("t5_cmd_ready", 32'(e_cmd_ready), 1);
    chk("t5_user_cmd_valid", 32'(e_user_cmd_valid), 0);
    step();
    cmd_valid0 = 0;
    #1;
    chk("t5_outstanding", 32'(e_outstanding), 1);
    step();
    chk("t5_rsp_valid", 32'(e_rsp_valid), 1);
    chk("t5_rsp_data", e_rsp_data, 32'hDEADBEEF);
    chk("t5_outstanding0", 32'(e_outstanding), 0);
    step();
    chk("t5_idle", 32'(e_busy), 0);

    // 6: asynchronous reset mid-operation
    cpu_rsp_ready = 0; cpu_cmd_valid = 1; fid = 10'h004;
    for (int i = 0; i < 4; i++) step();
    cpu_cmd_valid = 0;
    accel_rsp_valid = 1; accel_rsp_data = 32'h55;
    step();
    accel_rsp_valid = 0;
    chk("t6_pre_outstanding", 32'(outstanding), 3);
    chk("t6_pre_rsp_valid", 32'(cpu_rsp_valid), 1);
    rstn = 0;
    #1;
    chk("t6_outstanding", 32'(outstanding), 0);
    chk("t6_rsp_valid", 32'(cpu_rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    step();
    rstn = 1;
    step();
    accel_rsp_valid = 1;
    #1;
    chk("t6_late_rsp_unacked", 32'(accel_rsp_ready), 0);
    step();
    accel_rsp_valid = 0;
    chk("t6_no_rsp", 32'(cpu_rsp_valid), 0);

    // Randomized traffic against the ordering model, then a bounded drain
    for (int c = 0; c < 600; c++) rand_cycle(1'b0);
    for (int c = 0; c < 200 && (exp_all.size() != 0 || order_m.size() != 0); c++) rand_cycle(1'b1);
    chk("drain_words_left", 32'(exp_all.size()), 0);
    chk("drain_outstanding", 32'(outstanding), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
